// File: rtl/data_bus_pkg.sv
// data_bus_pkg
//   Shared constants for the data bus responder: default region bases, I/O
//   register offsets (relative to IO_BASE), TIMER_CTRL bit positions and the
//   internal address-decode select type.
//   No ports.
package data_bus_pkg;

  localparam logic [31:0] RAM_BASE_DEFAULT = 32'h1001_0000;
  localparam logic [31:0] IO_BASE_DEFAULT  = 32'h1001_0400;

  localparam logic [7:0] OFF_GPIO_OUT    = 8'h00;
  localparam logic [7:0] OFF_GPIO_IN     = 8'h04;
  localparam logic [7:0] OFF_TIMER_COUNT = 8'h08;
  localparam logic [7:0] OFF_TIMER_CMP   = 8'h0C;
  localparam logic [7:0] OFF_TIMER_CTRL  = 8'h10;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_FLAG_BIT = 1;
  localparam int CTRL_IE_BIT   = 2;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_GPIO_OUT,
    SEL_GPIO_IN,
    SEL_T_COUNT,
    SEL_T_CMP,
    SEL_T_CTRL
  } bus_sel_e;

  // Word index of an I/O offset, for comparison against (Address-IO_BASE)>>2.
  function automatic logic [5:0] io_word(input logic [7:0] off);
    return off[7:2];
  endfunction

endpackage

// File: rtl/timer_unit.sv
// timer_unit
//   Free-running compare timer. COUNT increments while EN=1; when COUNT equals
//   CMP (and EN=1) the next COUNT is 0 and FLAG sets. A bus write to COUNT wins
//   over increment/wrap; a FLAG set wins over a same-cycle W1C clear.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     i_wr_count/cmp/ctrl one-cycle write strobes (already decoded and gated)
//     i_wdata             store data
//     o_count, o_cmp      current COUNT / CMP
//     o_ctrl              {IE, FLAG, EN}
//     o_irq               FLAG & IE, from registered state only
module timer_unit
  import data_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wr_count,
  input  logic                  i_wr_cmp,
  input  logic                  i_wr_ctrl,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_count,
  output logic [DATA_WIDTH-1:0] o_cmp,
  output logic [2:0]            o_ctrl,
  output logic                  o_irq
);

  logic [DATA_WIDTH-1:0] r_count;
  logic [DATA_WIDTH-1:0] r_cmp;
  logic                  r_en;
  logic                  r_flag;
  logic                  r_ie;
  logic                  w_wrap;

  assign w_wrap = r_en && (r_count == r_cmp);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_cmp   <= '1;
      r_en    <= 1'b0;
      r_flag  <= 1'b0;
      r_ie    <= 1'b0;
    end else begin
      if (i_wr_count)
        r_count <= i_wdata;
      else if (w_wrap)
        r_count <= '0;
      else if (r_en)
        r_count <= r_count + DATA_WIDTH'(1);

      if (i_wr_cmp)
        r_cmp <= i_wdata;

      if (i_wr_ctrl) begin
        r_en <= i_wdata[CTRL_EN_BIT];
        r_ie <= i_wdata[CTRL_IE_BIT];
      end

      if (w_wrap)
        r_flag <= 1'b1;
      else if (i_wr_ctrl && i_wdata[CTRL_FLAG_BIT])
        r_flag <= 1'b0;
    end
  end

  always_comb begin
    o_ctrl = '0;
    o_ctrl[CTRL_EN_BIT]   = r_en;
    o_ctrl[CTRL_FLAG_BIT] = r_flag;
    o_ctrl[CTRL_IE_BIT]   = r_ie;
  end

  assign o_count = r_count;
  assign o_cmp   = r_cmp;
  assign o_irq   = r_flag & r_ie;

endmodule

// File: rtl/data_bus_responder.sv
// data_bus_responder
//   Memory-mapped responder for a single-cycle core: a word RAM at RAM_BASE
//   and an I/O block at IO_BASE (GPIO out/in, optional timer). Loads are
//   combinational from Address; stores commit on the rising clk edge.
//   Build option: define DATA_BUS_TIMER_EN to include the timer (offsets
//   0x08-0x10); without it those offsets read 0 and timer_irq is tied low.
//   Ports:
//     clk, reset      clock, synchronous active-high reset
//     MemWrite        store strobe
//     Address         byte address
//     WriteData       store data
//     ReadData        load data (same cycle)
//     gpio_in         external inputs (double-flop synchronized)
//     gpio_out        GPIO_OUT register
//     timer_irq       timer interrupt level
module data_bus_responder
  import data_bus_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] RAM_BASE     = DATA_WIDTH'(RAM_BASE_DEFAULT),
  parameter logic [DATA_WIDTH-1:0] IO_BASE      = DATA_WIDTH'(IO_BASE_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemWrite,
  input  logic [DATA_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData,
  input  logic [7:0]            gpio_in,
  output logic [7:0]            gpio_out,
  output logic                  timer_irq
);

  localparam int IDX_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [MEMORY_DEPTH];
  logic [7:0]            r_gpio_out;
  logic [7:0]            r_gpio_meta;
  logic [7:0]            r_gpio_sync;

  logic [DATA_WIDTH-1:0] w_ram_word;
  logic [DATA_WIDTH-1:0] w_io_word;
  logic                  w_ram_hit;
  logic                  w_io_hit;
  logic [IDX_W-1:0]      w_ram_idx;
  bus_sel_e              w_sel;
  logic                  w_we;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Word offsets; comparing whole words makes Address[1:0] irrelevant.
  assign w_ram_word = (Address - RAM_BASE) >> 2;
  assign w_io_word  = (Address - IO_BASE) >> 2;
  assign w_ram_hit  = (Address >= RAM_BASE) && (w_ram_word < DATA_WIDTH'(MEMORY_DEPTH));
  assign w_io_hit   = (Address >= IO_BASE);
  assign w_ram_idx  = w_ram_word[IDX_W-1:0];

  // Stores issued in a reset cycle are dropped everywhere, RAM included.
  assign w_we = MemWrite & ~reset;

  always_comb begin
    w_sel = SEL_NONE;
    if (w_ram_hit) begin
      w_sel = SEL_RAM;
    end else if (w_io_hit) begin
      if (w_io_word == DATA_WIDTH'(io_word(OFF_GPIO_OUT)))    w_sel = SEL_GPIO_OUT;
      if (w_io_word == DATA_WIDTH'(io_word(OFF_GPIO_IN)))     w_sel = SEL_GPIO_IN;
`ifdef DATA_BUS_TIMER_EN
      if (w_io_word == DATA_WIDTH'(io_word(OFF_TIMER_COUNT))) w_sel = SEL_T_COUNT;
      if (w_io_word == DATA_WIDTH'(io_word(OFF_TIMER_CMP)))   w_sel = SEL_T_CMP;
      if (w_io_word == DATA_WIDTH'(io_word(OFF_TIMER_CTRL)))  w_sel = SEL_T_CTRL;
`endif
    end
  end

  // RAM has no reset; contents survive a core reset.
  always_ff @(posedge clk) begin
    if (w_we && (w_sel == SEL_RAM))
      r_mem[w_ram_idx] <= WriteData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gpio_out  <= '0;
      r_gpio_meta <= '0;
      r_gpio_sync <= '0;
    end else begin
      r_gpio_meta <= gpio_in;
      r_gpio_sync <= r_gpio_meta;
      if (w_we && (w_sel == SEL_GPIO_OUT))
        r_gpio_out <= WriteData[7:0];
    end
  end

`ifdef DATA_BUS_TIMER_EN
  logic [DATA_WIDTH-1:0] w_t_count;
  logic [DATA_WIDTH-1:0] w_t_cmp;
  logic [2:0]            w_t_ctrl;

  timer_unit #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_wr_count (w_we && (w_sel == SEL_T_COUNT)),
    .i_wr_cmp   (w_we && (w_sel == SEL_T_CMP)),
    .i_wr_ctrl  (w_we && (w_sel == SEL_T_CTRL)),
    .i_wdata    (WriteData),
    .o_count    (w_t_count),
    .o_cmp      (w_t_cmp),
    .o_ctrl     (w_t_ctrl),
    .o_irq      (timer_irq)
  );
`else
  assign timer_irq = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      SEL_RAM:      w_rdata = r_mem[w_ram_idx];
      SEL_GPIO_OUT: w_rdata = DATA_WIDTH'(r_gpio_out);
      SEL_GPIO_IN:  w_rdata = DATA_WIDTH'(r_gpio_sync);
`ifdef DATA_BUS_TIMER_EN
      SEL_T_COUNT:  w_rdata = w_t_count;
      SEL_T_CMP:    w_rdata = w_t_cmp;
      SEL_T_CTRL:   w_rdata = DATA_WIDTH'(w_t_ctrl);
`endif
      default:      w_rdata = '0;
    endcase
  end

  assign ReadData = w_rdata;
  assign gpio_out = r_gpio_out;

endmodule

// File: tb/tb_data_bus_responder.sv
module tb_data_bus_responder;

  localparam logic [31:0] RAMB = 32'h1001_0000;
  localparam logic [31:0] IOB  = 32'h1001_0400;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic [7:0]  gpio_in = '0;
  logic [7:0]  gpio_out;
  logic        timer_irq;

  int checks = 0;
  int failures = 0;

  data_bus_responder dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  // Reference model: register contents as the programmer sees them.
  logic [31:0] m_mem [int];
  bit   [7:0]  m_gpio_out;
  bit   [7:0]  m_gin_hist [$];   // gpio_in value seen at each edge since reset
  bit   [31:0] m_count, m_cmp;
  bit          m_en, m_flag, m_ie;
  bit          m_valid = 1'b0;

  function automatic bit in_ram(input logic [31:0] a);
    return (a >= RAMB) && ((a - RAMB) < 32'd256);
  endfunction

  function automatic bit model_known(input logic [31:0] a);
    if (in_ram(a)) return m_mem.exists(int'((a - RAMB) >> 2));
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (in_ram(a)) return m_mem[int'((a - RAMB) >> 2)];
    if (a == IOB)        return {24'h0, m_gpio_out};
    if (a == IOB + 4)    return {24'h0, m_gin_hist[m_gin_hist.size() - 2]};
`ifdef DATA_BUS_TIMER_EN
    if (a == IOB + 8)    return m_count;
    if (a == IOB + 12)   return m_cmp;
    if (a == IOB + 16)   return {29'h0, m_ie, m_flag, m_en};
`endif
    return 32'h0;
  endfunction

  function automatic bit model_irq();
`ifdef DATA_BUS_TIMER_EN
    return m_flag & m_ie;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_edge(input bit we, input logic [31:0] a,
                                     input logic [31:0] d, input bit rst,
                                     input logic [7:0] gin);
    bit [31:0] nxt_count;
    bit        nxt_flag;
    bit        hit;
    if (rst) begin
      m_gpio_out = 8'h0;
      m_count = 32'h0; m_cmp = 32'hFFFF_FFFF;
      m_en = 1'b0; m_flag = 1'b0; m_ie = 1'b0;
      m_gin_hist = {8'h0, 8'h0};
      m_valid = 1'b1;
      return;
    end
    m_gin_hist.push_back(gin);
    if (m_gin_hist.size() > 3) void'(m_gin_hist.pop_front());
    hit = m_en && (m_count == m_cmp);
    nxt_count = m_en ? (hit ? 32'h0 : m_count + 32'd1) : m_count;
    nxt_flag  = m_flag;
    if (we && a == IOB + 16 && d[1]) nxt_flag = 1'b0;
    if (hit) nxt_flag = 1'b1;
    if (we) begin
      if (in_ram(a)) m_mem[int'((a - RAMB) >> 2)] = d;
      if (a == IOB)      m_gpio_out = d[7:0];
      if (a == IOB + 8)  nxt_count = d;
      if (a == IOB + 12) m_cmp = d;
      if (a == IOB + 16) begin m_en = d[0]; m_ie = d[2]; end
    end
    m_count = nxt_count;
    m_flag  = nxt_flag;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive at negedge, check the load before the edge, then
  // advance the model across the edge and check the registered outputs.
  task automatic cyc(input bit we, input logic [31:0] a, input logic [31:0] d,
                     input bit rst, output logic [31:0] rd);
    @(negedge clk);
    MemWrite = we; Address = a; WriteData = d; reset = rst;
    #1;
    rd = ReadData;
    if (m_valid && model_known(a)) check("model_rd", ReadData, model_read(a));
    @(posedge clk);
    model_edge(we, a, d, rst, gpio_in);
    #1;
    check("model_gpio_out", {24'h0, gpio_out}, {24'h0, m_gpio_out});
    check("model_irq", {31'h0, timer_irq}, {31'h0, model_irq()});
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel <= 2) return RAMB + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
    if (sel == 3) return RAMB + 32'h100 + 32'($urandom_range(0, 15) << 2);
    if (sel <= 8) return IOB + 32'($urandom_range(0, 4) << 2);
    return ($urandom_range(0, 1) == 1) ? IOB + 32'h14 : 32'($urandom);
  endfunction

  initial begin
    logic [31:0] rd;
    logic [31:0] a, d;

    // reset
    cyc(0, 32'h0, 32'h0, 1, rd);
    cyc(0, 32'h0, 32'h0, 1, rd);
    cyc(0, IOB, 32'h0, 0, rd);
    check("rst_gpio_out_rd", rd, 32'h0);
    check("rst_irq", {31'h0, timer_irq}, 32'h0);

    // RAM
    cyc(1, RAMB + 32'h8, 32'hDEAD_BEEF, 0, rd);
    cyc(0, RAMB + 32'h8, 32'h0, 0, rd);
    check("ram_rd", rd, 32'hDEAD_BEEF);
    cyc(0, RAMB + 32'h100, 32'h0, 0, rd);
    check("ram_past_depth", rd, 32'h0);
    cyc(1, RAMB + 32'h100, 32'h1234_5678, 0, rd);
    cyc(0, RAMB + 32'h100, 32'h0, 0, rd);
    check("ram_past_depth_wr", rd, 32'h0);

    // GPIO
    cyc(1, IOB, 32'h0000_01A5, 0, rd);
    check("gpio_out_pin", {24'h0, gpio_out}, 32'hA5);
    cyc(0, IOB, 32'h0, 0, rd);
    check("gpio_out_rd", rd, 32'hA5);
    gpio_in = 8'h3C;
    cyc(1, IOB + 4, 32'hFF, 0, rd);
    check("gpio_in_0", rd, 32'h0);
    cyc(0, IOB + 4, 32'h0, 0, rd);
    check("gpio_in_1", rd, 32'h0);
    cyc(0, IOB + 4, 32'h0, 0, rd);
    check("gpio_in_2", rd, 32'h3C);

`ifdef DATA_BUS_TIMER_EN
    cyc(0, IOB + 12, 32'h0, 0, rd);
    check("rst_cmp", rd, 32'hFFFF_FFFF);
    cyc(1, IOB + 12, 32'd3, 0, rd);
    cyc(1, IOB + 16, 32'd5, 0, rd);
    for (int i = 0; i < 5; i++) begin
      cyc(0, IOB + 8, 32'h0, 0, rd);
      check($sformatf("tmr_count_%0d", i), rd, 32'(i % 4));
      if (i == 3) check("tmr_irq_set", {31'h0, timer_irq}, 32'h1);
      if (i < 3)  check("tmr_irq_low", {31'h0, timer_irq}, 32'h0);
    end
    cyc(0, IOB + 16, 32'h0, 0, rd);
    check("tmr_ctrl_flag", rd, 32'h7);
    cyc(1, IOB + 16, 32'h7, 0, rd);
    check("tmr_w1c_irq", {31'h0, timer_irq}, 32'h0);
    // COUNT is now 3: write on the wrap cycle
    cyc(1, IOB + 8, 32'd10, 0, rd);
    check("prio_wrap_rd", rd, 32'd3);
    check("prio_flag_sets", {31'h0, timer_irq}, 32'h1);
    cyc(0, IOB + 8, 32'h0, 0, rd);
    check("prio_count_wr", rd, 32'd10);
    cyc(1, IOB + 16, 32'h7, 0, rd);
    check("prio_clear", {31'h0, timer_irq}, 32'h0);
    cyc(1, IOB + 8, 32'd2, 0, rd);
    cyc(0, IOB + 8, 32'h0, 0, rd);
    check("prio_count2", rd, 32'd2);
    cyc(1, IOB + 16, 32'h7, 0, rd);
    check("prio_set_over_w1c", {31'h0, timer_irq}, 32'h1);
    cyc(0, IOB + 16, 32'h0, 0, rd);
    check("prio_ctrl", rd, 32'h7);
    cyc(0, IOB + 8, 32'h0, 0, rd);
    check("pre_rst_count", rd, 32'd1);
    // COUNT=2, EN=1: reset with a GPIO_OUT store pending
    cyc(1, IOB, 32'hFF, 1, rd);
    check("rst_gpio_pin", {24'h0, gpio_out}, 32'h0);
    check("rst_irq2", {31'h0, timer_irq}, 32'h0);
    cyc(0, IOB + 4, 32'h0, 0, rd);
    check("rst_sync", rd, 32'h0);
    cyc(0, IOB + 8, 32'h0, 0, rd);
    check("rst_count", rd, 32'h0);
    cyc(0, IOB + 12, 32'h0, 0, rd);
    check("rst_cmp2", rd, 32'hFFFF_FFFF);
    cyc(0, IOB + 16, 32'h0, 0, rd);
    check("rst_ctrl", rd, 32'h0);
`else
    cyc(1, IOB + 12, 32'd3, 0, rd);
    cyc(1, IOB + 16, 32'd5, 0, rd);
    cyc(1, IOB + 8, 32'd3, 0, rd);
    for (int i = 0; i < 6; i++) begin
      cyc(0, IOB + 8 + 32'((i % 3) * 4), 32'h0, 0, rd);
      check($sformatf("notmr_rd_%0d", i), rd, 32'h0);
      check("notmr_irq", {31'h0, timer_irq}, 32'h0);
    end
    cyc(1, IOB, 32'hFF, 1, rd);
    check("rst_gpio_pin", {24'h0, gpio_out}, 32'h0);
`endif
    cyc(0, IOB, 32'h0, 0, rd);
    check("rst_gpio_rd", rd, 32'h0);
    cyc(0, RAMB + 32'h8, 32'h0, 0, rd);
    check("rst_ram_kept", rd, 32'hDEAD_BEEF);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) gpio_in = 8'($urandom);
      a = rand_addr();
      d = $urandom;
      if ($urandom_range(0, 1) == 1) d = d & 32'h1F;
      cyc(bit'($urandom_range(0, 1)), a, d, ($urandom_range(0, 63) == 0), rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
